// File: rtl/dr_pkg.sv
// Shared types for the ping-pong input buffer: read selectors, half states, read pipe control.
package dr_pkg;

  typedef enum logic [1:0] {RR = 2'b00, BR = 2'b01, RP = 2'b10, NE = 2'b11} rpsel_e;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} half_st_e;

  localparam int RD_LAT = 3;

  // Control that travels alongside a read through the pipe.
  typedef struct packed {
    rpsel_e     sel;
    logic [7:0] lane;   // resolved bank index for BR/RP
    logic       zero;   // force all lanes to 0
  } rd_ctl_t;

endpackage

// File: rtl/inbuf_bank.sv
// One pixel bank holding both halves: single write port, single registered read port.
module inbuf_bank #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dw_input_buffer.sv
// Ping-pong pixel store: DMA fills one half while buffer_if reads the other (3-cycle read).
// Optional INBUF_ZPAD_EN: out-of-range row/col/bank reads return zero instead of wrapping.
module dw_input_buffer
  import dr_pkg::*;
#(
  parameter int POY  = 3,
  parameter int DW   = 8,
  parameter int ROWS = 8,
  parameter int COLS = 28,
  parameter int RLAT = RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_last,
  input  logic [1:0]        rpsel,
  input  logic [7:0]        bank,
  input  logic [7:0]        row,
  input  logic [27:0]       col,
  output logic [POY*DW-1:0] rd_data,
  output logic              rd_valid,
  input  logic              blk_done,
  output logic              blkend
);

  localparam int BW = (POY  > 1) ? $clog2(POY)  : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  // Word address = {half, row, col}; rows/cols padded to powers of two so truncation wraps cleanly.
  localparam int AW = 1 + RW + CW;

  // ---------------- half FSMs ----------------
  half_st_e st_q [2];
  half_st_e st_n [2];
  logic     wptr_q, wptr_n, rptr_q, rptr_n, rnext_q, rnext_n;
  logic     handoff, wr_rdy_n;

  logic [BW-1:0] wb_q;
  logic [RW-1:0] wrow_q;
  logic [CW-1:0] wcol_q;
  logic          wr_fire, wr_end;

  assign wr_fire = wr_valid & wr_ready;
  assign wr_end  = wr_fire & (wr_last | ((wb_q == BW'(POY-1)) & (wrow_q == RW'(ROWS-1)) &
                                         (wcol_q == CW'(COLS-1))));

  // Release and hand-off are chained so blk_done and a fresh FULL can swap in one cycle.
  always_comb begin
    st_n    = st_q;
    wptr_n  = wptr_q;
    rptr_n  = rptr_q;
    rnext_n = rnext_q;
    handoff = 1'b0;
    if (wr_fire) begin
      if (wr_end) begin
        st_n[wptr_q] = FULL;
        wptr_n       = ~wptr_q;
      end else begin
        st_n[wptr_q] = FILLING;
      end
    end
    if (blk_done && st_q[rptr_q] == READING) st_n[rptr_q] = EMPTY;
    if (st_n[0] != READING && st_n[1] != READING && st_n[rnext_q] == FULL) begin
      st_n[rnext_q] = READING;
      rptr_n        = rnext_q;
      rnext_n       = ~rnext_q;
      handoff       = 1'b1;
    end
    wr_rdy_n = (st_n[wptr_n] == EMPTY) || (st_n[wptr_n] == FILLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      rnext_q  <= 1'b0;
      wr_ready <= 1'b0;
      blkend   <= 1'b0;
    end else begin
      st_q     <= st_n;
      wptr_q   <= wptr_n;
      rptr_q   <= rptr_n;
      rnext_q  <= rnext_n;
      wr_ready <= wr_rdy_n;
      blkend   <= handoff;
    end
  end

  // ---------------- write counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q   <= '0;
      wrow_q <= '0;
      wcol_q <= '0;
    end else if (wr_fire) begin
      if (wr_end) begin
        wb_q   <= '0;
        wrow_q <= '0;
        wcol_q <= '0;
      end else if (wcol_q == CW'(COLS-1)) begin
        wcol_q <= '0;
        if (wrow_q == RW'(ROWS-1)) begin
          wrow_q <= '0;
          wb_q   <= wb_q + 1'b1;
        end else begin
          wrow_q <= wrow_q + 1'b1;
        end
      end else begin
        wcol_q <= wcol_q + 1'b1;
      end
    end
  end

  // ---------------- read pipe ----------------
  logic [RLAT:0]             vld_pipe;
  rd_ctl_t                   req_n, ctl1, ctl2;
  logic [AW-1:0]             raddr1;
  logic [POY-1:0][DW-1:0]    bout, lanes_n;
  logic                      unused_bits;

  assign vld_pipe[0] = (rpsel_e'(rpsel) != NE);
  assign rd_valid    = vld_pipe[RLAT];
  assign unused_bits = ^{ctl2.lane, col, row};

  always_comb begin
    req_n     = '0;
    req_n.sel = rpsel_e'(rpsel);
`ifdef INBUF_ZPAD_EN
    req_n.lane = bank;
    req_n.zero = (st_q[rptr_q] != READING) || (row >= 8'(ROWS)) || (col >= 28'(COLS)) ||
                 ((req_n.sel == BR || req_n.sel == RP) && bank >= 8'(POY));
`else
    req_n.lane = (bank >= 8'(POY)) ? 8'(POY-1) : bank;
    req_n.zero = (st_q[rptr_q] != READING);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[RLAT:1] <= '0;
      ctl1             <= '0;
      ctl2             <= '0;
      raddr1           <= '0;
    end else begin
      vld_pipe[RLAT:1] <= vld_pipe[RLAT-1:0];
      ctl1             <= req_n;
      ctl2             <= ctl1;
      raddr1           <= {rptr_q, row[RW-1:0], col[CW-1:0]};
    end
  end

  for (genvar g = 0; g < POY; g++) begin : g_bank
    inbuf_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wb_q == BW'(g))),
      .waddr ({wptr_q, wrow_q, wcol_q}),
      .wdata (wr_data),
      .raddr (raddr1),
      .rdata (bout[g])
    );
  end

  always_comb begin
    lanes_n = '0;
    if (!ctl2.zero) begin
      case (ctl2.sel)
        RR:      lanes_n          = bout;
        BR:      lanes_n[POY-1]   = bout[ctl2.lane[BW-1:0]];
        RP:      lanes_n[0]       = bout[ctl2.lane[BW-1:0]];
        default: lanes_n          = '0;
      endcase
    end
  end

  // NE slots leave rd_data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_data <= '0;
    else if (vld_pipe[RLAT-1]) rd_data <= lanes_n;
  end

endmodule

// File: tb/tb_dw_input_buffer.sv
// Directed bench for dw_input_buffer: fill/hand-off, read selectors, backpressure, wr_last, reset.
module tb_dw_input_buffer;
  import dr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0, wr_ready, wr_last = 1'b0, blk_done = 1'b0, blkend, rd_valid;
  logic [7:0]  wr_data = '0, bank = '0, row = '0;
  logic [27:0] col = '0;
  logic [1:0]  rpsel = 2'b11;
  logic [23:0] rd_data;

  int n_chk = 0, n_err = 0, blk_cnt = 0;

  always #5 clk = ~clk;

  dw_input_buffer dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_last(wr_last), .rpsel(rpsel), .bank(bank), .row(row), .col(col), .rd_data(rd_data),
    .rd_valid(rd_valid), .blk_done(blk_done), .blkend(blkend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(int base, int b, int r, int c);
    return 8'((base + b*224 + r*28 + c) % 256);
  endfunction

  function automatic logic [23:0] ln(logic [7:0] l0, logic [7:0] l1, logic [7:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One pixel; returns #1 after the accepting edge with wr_valid still high.
  task automatic push(input logic [7:0] d, input logic last);
    int t = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    while (!wr_ready && t < 200) begin tick(); t++; end
    if (!wr_ready) chk("push_timeout", wr_ready, 1);
    tick();
    wr_last = 1'b0;
    if (blkend) blk_cnt++;
  endtask

  task automatic rd_chk(input string tag, input rpsel_e s, input int b, input int r,
                        input int c, input logic [23:0] exp);
    rpsel = s; bank = 8'(b); row = 8'(r); col = 28'(c);
    tick();
    rpsel = NE;
    tick(); chk({tag, "_v2"}, rd_valid, 0);
    tick(); chk({tag, "_v3"}, rd_valid, 1); chk({tag, "_d"}, rd_data, exp);
  endtask

  initial begin
    logic [23:0] last_d;
    int b0, seen;

    // reset state
    repeat (3) tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data",  rd_data,  0);
    chk("rst_blkend",   blkend,   0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_wr_ready", wr_ready, 1);

    // blk_done with nothing reading is ignored; a read with no read half returns valid zero
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    chk("idle_blk_done_blkend", blkend, 0);
    rd_chk("rd_noread", RR, 0, 2, 5, 24'h0);

    // 1. fill half 0
    blk_cnt = 0;
    for (int p = 0; p < 672; p++) push(8'(p % 256), 1'b0);
    wr_valid = 1'b0;
    chk("h0_blkend_last", blkend, 1);
    chk("h0_blkend_count", blk_cnt, 1);
    chk("h0_wr_ready", wr_ready, 1);
    tick();
    chk("h0_blkend_pulse", blkend, 0);

    // 2./3. read selectors on half 0
    rd_chk("rr_r2c5", RR, 0, 2, 5, ln(pix(0,0,2,5), pix(0,1,2,5), pix(0,2,2,5)));
    last_d = ln(pix(0,0,2,5), pix(0,1,2,5), pix(0,2,2,5));
    rpsel = NE; repeat (3) tick();
    chk("ne_valid", rd_valid, 0);
    chk("ne_hold", rd_data, last_d);
    rd_chk("br_b1r0c27", BR, 1, 0, 27, ln(8'h0, 8'h0, pix(0,1,0,27)));
    rd_chk("rp_b2r7c0",  RP, 2, 7, 0,  ln(pix(0,2,7,0), 8'h0, 8'h0));

    // 5. out-of-range indices
`ifdef INBUF_ZPAD_EN
    rd_chk("rr_row8", RR, 0, 8, 5, 24'h0);
    rd_chk("rr_col28", RR, 0, 1, 28, 24'h0);
    rd_chk("br_bank5", BR, 5, 1, 1, 24'h0);
`else
    rd_chk("rr_row8", RR, 0, 8, 5, ln(pix(0,0,0,5), pix(0,1,0,5), pix(0,2,0,5)));
    rd_chk("br_bank5", BR, 5, 1, 1, ln(8'h0, 8'h0, pix(0,2,1,1)));
`endif

    // 4. fill half 1 while half 0 is still being read
    blk_cnt = 0;
    for (int p = 0; p < 672; p++) push(8'((672 + p) % 256), 1'b0);
    wr_valid = 1'b0;
    chk("h1_wr_ready_full", wr_ready, 0);
    chk("h1_no_blkend", blk_cnt, 0);
    repeat (3) tick();
    chk("h1_wr_ready_hold", wr_ready, 0);
    chk("h1_blkend_hold", blkend, 0);
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    chk("h1_handoff_blkend", blkend, 1);
    chk("h1_wr_ready_free", wr_ready, 1);
    rd_chk("h1_rr_r0c0", RR, 0, 0, 0, ln(pix(672,0,0,0), pix(672,1,0,0), pix(672,2,0,0)));
    rd_chk("h1_rp_b1r3c9", RP, 1, 3, 9, ln(pix(672,1,3,9), 8'h0, 8'h0));

    // wr_last closes half 0 early; no hand-off until half 1 is released
    blk_cnt = 0;
    for (int k = 0; k < 5; k++) push(8'(8'hA0 + k), k == 4);
    wr_valid = 1'b0;
    chk("last_wr_ready", wr_ready, 0);
    chk("last_no_blkend", blk_cnt, 0);
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    chk("last_handoff_blkend", blkend, 1);
    chk("last_wr_ready_free", wr_ready, 1);
    rd_chk("last_rp_b0c4", RP, 0, 0, 4, ln(8'hA4, 8'h0, 8'h0));

    // 6. reset mid-fill with reads in flight
    for (int k = 0; k < 3; k++) push(8'(k), 1'b0);
    wr_valid = 1'b0;
    rpsel = RR; row = 8'd0; col = 28'd0;
    tick(); row = 8'd1;
    tick(); rpsel = NE;
    tick();
    chk("pre_rst_rd_valid", rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    b0 = 0; seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (blkend) b0++;
      if (rd_valid) seen++;
    end
    chk("post_rst_no_blkend", b0, 0);
    chk("post_rst_no_stale_rd", seen, 0);
    chk("post_rst2_wr_ready", wr_ready, 1);
    rd_chk("post_rst_rd_zero", RR, 0, 0, 0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
